// File: rtl/src_arb_pkg.sv
// rtl/src_arb_pkg.sv - shared types and defaults for the nibble source arbiter
package src_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_EXT = 2'd1,
        GNT_INT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_EXT = 1'b0,
        OWN_INT = 1'b1
    } owner_e;

    localparam int DATA_W_DEF    = 4;
    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/nibble_src_arbiter.sv
// rtl/nibble_src_arbiter.sv - round-robin, burst-bounded arbiter for ext/int nibble sources
// Optional transfer statistics: SRC_ARB_STATS_EN
module nibble_src_arbiter
    import src_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_req,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              int_req,
    input  logic [DATA_W-1:0] int_data,
    output logic              ext_gnt,
    output logic              int_gnt,
    output logic              sel_ext,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  ext_xfer_cnt,
    output logic [CNT_W-1:0]  int_xfer_cnt
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_last_owner;
    owner_e            w_owner_nxt;
    logic [3:0]        r_burst_cnt;
    logic [3:0]        w_burst_nxt;
    logic              r_sel_ext;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              w_xfer_ext;
    logic              w_xfer_int;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_last_owner;
        w_burst_nxt = r_burst_cnt;
        w_xfer_ext  = 1'b0;
        w_xfer_int  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ext_req && int_req) begin
                    w_state_nxt = (r_last_owner == OWN_INT) ? GNT_EXT : GNT_INT;
                end else if (ext_req) begin
                    w_state_nxt = GNT_EXT;
                end else if (int_req) begin
                    w_state_nxt = GNT_INT;
                end
            end
            GNT_EXT: begin
                if (!ext_req) begin
                    w_state_nxt = IDLE;
                    w_burst_nxt = 4'd0;
                    w_owner_nxt = OWN_EXT;
                end else begin
                    w_xfer_ext = 1'b1;
                    if (r_burst_cnt == BURST_LAST) begin
                        // A full burst only forces a handover when the other side is waiting
                        w_burst_nxt = 4'd0;
                        if (int_req) begin
                            w_state_nxt = GNT_INT;
                            w_owner_nxt = OWN_EXT;
                        end
                    end else begin
                        w_burst_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            GNT_INT: begin
                if (!int_req) begin
                    w_state_nxt = IDLE;
                    w_burst_nxt = 4'd0;
                    w_owner_nxt = OWN_INT;
                end else begin
                    w_xfer_int = 1'b1;
                    if (r_burst_cnt == BURST_LAST) begin
                        w_burst_nxt = 4'd0;
                        if (ext_req) begin
                            w_state_nxt = GNT_EXT;
                            w_owner_nxt = OWN_INT;
                        end
                    end else begin
                        w_burst_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_burst_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_INT;
            r_burst_cnt  <= 4'd0;
            r_sel_ext    <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_owner_nxt;
            r_burst_cnt  <= w_burst_nxt;
            // Select follows the grant; it holds its last value while idle
            if (w_state_nxt == GNT_EXT) begin
                r_sel_ext <= 1'b1;
            end else if (w_state_nxt == GNT_INT) begin
                r_sel_ext <= 1'b0;
            end
            r_out_valid <= w_xfer_ext | w_xfer_int;
            if (w_xfer_ext) begin
                r_out_data <= ext_data;
            end else if (w_xfer_int) begin
                r_out_data <= int_data;
            end
        end
    end

    assign ext_gnt   = (r_state == GNT_EXT);
    assign int_gnt   = (r_state == GNT_INT);
    assign sel_ext   = r_sel_ext;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef SRC_ARB_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_ext_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_xfer_ext),
        .count (ext_xfer_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_int_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_xfer_int),
        .count (int_xfer_cnt)
    );
`else
    assign ext_xfer_cnt = '0;
    assign int_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_nibble_src_arbiter.sv
// tb/tb_nibble_src_arbiter.sv - self-checking bench for nibble_src_arbiter (SRC_ARB_STATS_EN aware)
module tb_nibble_src_arbiter;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ext_req = 1'b0;
    logic [3:0] ext_data = 4'h0;
    logic       int_req = 1'b0;
    logic [3:0] int_data = 4'h0;
    logic       ext_gnt, int_gnt, sel_ext, out_valid;
    logic [3:0] out_data;
    logic [7:0] ext_xfer_cnt, int_xfer_cnt;

    nibble_src_arbiter #(.DATA_W(4), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ext_req      (ext_req),
        .ext_data     (ext_data),
        .int_req      (int_req),
        .int_data     (int_data),
        .ext_gnt      (ext_gnt),
        .int_gnt      (int_gnt),
        .sel_ext      (sel_ext),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .ext_xfer_cnt (ext_xfer_cnt),
        .int_xfer_cnt (int_xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner 0 = nobody, 1 = external, 2 = internal
    int         m_own;
    int         m_last;
    int         m_run;
    logic       m_sel;
    logic       m_valid;
    logic [3:0] m_data;
    int         m_ecnt;
    int         m_icnt;

    wire [23:0] dut_vec = {ext_gnt, int_gnt, sel_ext, out_valid, out_data, ext_xfer_cnt, int_xfer_cnt};

    function automatic logic [23:0] exp_vec();
        logic [7:0] e8, i8;
`ifdef SRC_ARB_STATS_EN
        e8 = 8'(m_ecnt);
        i8 = 8'(m_icnt);
`else
        e8 = 8'h00;
        i8 = 8'h00;
`endif
        return {(m_own == 1), (m_own == 2), m_sel, m_valid, m_data, e8, i8};
    endfunction

    task automatic model_reset();
        m_own = 0; m_last = 2; m_run = 0;
        m_sel = 1'b0; m_valid = 1'b0; m_data = 4'h0;
        m_ecnt = 0; m_icnt = 0;
    endtask

    task automatic model_edge(input logic er, input logic [3:0] ed, input logic ir, input logic [3:0] id);
        logic mine, other;
        if (m_own == 0) begin
            m_valid = 1'b0;
            if (er && ir) m_own = (m_last == 1) ? 2 : 1;
            else if (er)  m_own = 1;
            else if (ir)  m_own = 2;
        end else begin
            mine  = (m_own == 1) ? er : ir;
            other = (m_own == 1) ? ir : er;
            if (!mine) begin
                m_valid = 1'b0;
                m_last  = m_own;
                m_own   = 0;
                m_run   = 0;
            end else begin
                m_valid = 1'b1;
                m_data  = (m_own == 1) ? ed : id;
                if (m_own == 1) m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
                else            m_icnt = (m_icnt < 255) ? m_icnt + 1 : 255;
                m_run++;
                if (m_run == BURST_MAX) begin
                    m_run = 0;
                    if (other) begin
                        m_last = m_own;
                        m_own  = 3 - m_own;
                    end
                end
            end
        end
        if (m_own == 1)      m_sel = 1'b1;
        else if (m_own == 2) m_sel = 1'b0;
    endtask

    task automatic step(input logic er, input logic [3:0] ed, input logic ir, input logic [3:0] id);
        ext_req = er; ext_data = ed; int_req = ir; int_data = id;
        model_edge(er, ed, ir, id);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ext_req = 1'b0; int_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ext_req = 1'b1; int_req = 1'b1; ext_data = 4'h5; int_data = 4'h6;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== 24'h0) $display("FAIL reset_hold: got %h want %h", dut_vec, 24'h0);
        else n_pass++;
        rst_n = 1'b1;
        step(1'b1, 4'h5, 1'b1, 4'h6);
        n_checks++;
        if ({ext_gnt, int_gnt, sel_ext} !== 3'b101) $display("FAIL reset_first_tie: got %b want 101", {ext_gnt, int_gnt, sel_ext});
        else n_pass++;
        step(1'b1, 4'h5, 1'b1, 4'h6);
        step(1'b1, 4'h7, 1'b1, 4'h6);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 24'h0) $display("FAIL reset_async: got %h want %h", dut_vec, 24'h0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 4'h0, 1'b0, 4'h0);
        n_checks++;
        if (dut_vec !== exp_vec() || out_valid !== 1'b0) $display("FAIL reset_release_idle: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_single_ext();
        logic [3:0] pat [3];
        pat = '{4'hA, 4'hB, 4'hC};
        apply_reset();
        step(1'b1, pat[0], 1'b0, 4'h0);
        n_checks++;
        if ({ext_gnt, sel_ext, out_valid} !== 3'b110) $display("FAIL single_grant: got %b want 110", {ext_gnt, sel_ext, out_valid});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pat[i], 1'b0, 4'h0);
            n_checks++;
            if ({out_valid, out_data, ext_gnt} !== {1'b1, pat[i], 1'b1}) $display("FAIL single_xfer%0d: got %b want %b", i, {out_valid, out_data, ext_gnt}, {1'b1, pat[i], 1'b1});
            else n_pass++;
        end
        step(1'b0, 4'h0, 1'b0, 4'h0);
        n_checks++;
        if ({ext_gnt, int_gnt, out_valid} !== 3'b000 || dut_vec !== exp_vec()) $display("FAIL single_release: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_fairness();
        int xfers;
        logic want_int;
        apply_reset();
        xfers = 0;
        step(1'b1, 4'($urandom_range(0, 7)), 1'b1, 4'($urandom_range(8, 15)));
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 4'($urandom_range(0, 7)), 1'b1, 4'($urandom_range(8, 15)));
            want_int = ((xfers / BURST_MAX) % 2) == 1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data[3] !== want_int || (ext_gnt && int_gnt))
                $display("FAIL fairness_xfer%0d: got valid=%b src_int=%b gnts=%b%b want valid=1 src_int=%b", xfers, out_valid, out_data[3], ext_gnt, int_gnt, want_int);
            else n_pass++;
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL fairness_model%0d: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
            xfers++;
        end
    endtask

    task automatic test_tie_after_release();
        apply_reset();
        step(1'b1, 4'h1, 1'b0, 4'h0);
        step(1'b1, 4'h2, 1'b0, 4'h0);
        step(1'b0, 4'h0, 1'b0, 4'h0);
        step(1'b1, 4'h3, 1'b1, 4'h4);
        n_checks++;
        if ({ext_gnt, int_gnt, sel_ext} !== 3'b010) $display("FAIL tie_after_ext: got %b want 010", {ext_gnt, int_gnt, sel_ext});
        else n_pass++;
        step(1'b1, 4'h3, 1'b1, 4'h4);
        n_checks++;
        if ({out_valid, out_data} !== 5'b1_0100 || dut_vec !== exp_vec()) $display("FAIL tie_first_word: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_burst_wrap();
        int nvalid;
        apply_reset();
        nvalid = 0;
        step(1'b0, 4'h0, 1'b1, 4'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'h0, 1'b1, 4'($urandom));
            if (out_valid === 1'b1) nvalid++;
            n_checks++;
            if (int_gnt !== 1'b1 || dut_vec !== exp_vec()) $display("FAIL burst_wrap%0d: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (nvalid != 10) $display("FAIL burst_wrap_count: got %0d want 10", nvalid);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) != 0), 4'($urandom));
            n_checks++;
            if (dut_vec !== exp_vec() || (ext_gnt && int_gnt)) $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        apply_reset();
        for (int i = 0; i < 301; i++) step(1'b1, 4'($urandom), 1'b0, 4'h0);
`ifdef SRC_ARB_STATS_EN
        want = 16'hFF00;
`else
        want = 16'h0000;
`endif
        n_checks++;
        if ({ext_xfer_cnt, int_xfer_cnt} !== want) $display("FAIL stats_saturate: got %h want %h", {ext_xfer_cnt, int_xfer_cnt}, want);
        else n_pass++;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL stats_model: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_ext();
        test_fairness();
        test_tie_after_release();
        test_burst_wrap();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
